// File: rtl/miter_result_checker_if.sv
// Beat stream from the miter into the result checker: gold/gate vectors, don't-care mask,
// end-of-run marker and a valid/ready handshake.
interface miter_result_checker_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_gold;
  logic [WIDTH-1:0] in_gate;
  logic [WIDTH-1:0] in_mask;
  logic             in_last;

  modport master (
    output in_valid,
    output in_gold,
    output in_gate,
    output in_mask,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_gold,
    input  in_gate,
    input  in_mask,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/miter_result_checker.sv
// Judges miter gold/gate beat pairs: two-stage compare pipeline with pass/fail, mismatch count
// and first-failure capture. Define MITER_STOP_ON_FAIL_EN to end the run at the first failure.
module miter_result_checker #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  miter_result_checker_if.slave in_if,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     mismatch_cnt,
  output logic [CNT_W-1:0]     first_idx,
  output logic [WIDTH-1:0]     first_diff
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   s1_diff_q, s1_diff_d;
  logic [CNT_W-1:0]   s1_idx_q, s1_idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   fidx_q, fidx_d;
  logic [WIDTH-1:0]   fdiff_q, fdiff_d;
  logic               fail_q, fail_d;

  logic               xfer;
  logic               s1_fail;

  assign xfer    = in_if.in_valid && (state_q == StRun);
  assign s1_fail = s1_valid_q && (s1_diff_q != '0);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    s1_valid_d = 1'b0;
    s1_diff_d  = s1_diff_q;
    s1_idx_d   = s1_idx_q;
    cnt_d      = cnt_q;
    fidx_d     = fidx_q;
    fdiff_d    = fdiff_q;
    fail_d     = fail_q;

    // Stage 1: capture the masked difference of the accepted beat.
    if (xfer) begin
      s1_valid_d = 1'b1;
      s1_diff_d  = (in_if.in_gold ^ in_if.in_gate) & ~in_if.in_mask;
      s1_idx_d   = idx_q;
      idx_d      = idx_q + 1'b1;
    end

    // Stage 2: fold the previous beat into the result fields.
    if (s1_fail) begin
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (!fail_q) begin
        fidx_d  = s1_idx_q;
        fdiff_d = s1_diff_q;
        fail_d  = 1'b1;
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          idx_d   = '0;
          cnt_d   = '0;
          fidx_d  = '0;
          fdiff_d = '0;
          fail_d  = 1'b0;
        end
      end
      StRun: begin
        if (xfer && in_if.in_last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef MITER_STOP_ON_FAIL_EN
    // First failure ends the run; a beat taken on this same edge is dropped uncounted.
    if (s1_fail && !fail_q) begin
      state_d    = StDone;
      s1_valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_diff_q  <= '0;
      s1_idx_q   <= '0;
      cnt_q      <= '0;
      fidx_q     <= '0;
      fdiff_q    <= '0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      s1_valid_q <= s1_valid_d;
      s1_diff_q  <= s1_diff_d;
      s1_idx_q   <= s1_idx_d;
      cnt_q      <= cnt_d;
      fidx_q     <= fidx_d;
      fdiff_q    <= fdiff_d;
      fail_q     <= fail_d;
    end
  end

  assign in_if.in_ready = (state_q == StRun);
  assign busy           = (state_q == StRun) || (state_q == StDrain);
  assign done           = (state_q == StDone);
  assign pass           = (state_q == StDone) && !fail_q;
  assign mismatch_cnt   = cnt_q;
  assign first_idx      = fidx_q;
  assign first_diff     = fdiff_q;

endmodule

// File: tb/tb_miter_result_checker.sv
// Bench for miter_result_checker: vector table, hand-written corner sequences and random runs
// checked against a run-level reference model. Honours MITER_STOP_ON_FAIL_EN when defined.
module tb_miter_result_checker;
  localparam int unsigned W   = 32;
  localparam int unsigned CW  = 16;
  localparam int unsigned CW4 = 4;

  logic clk = 1'b0;
  logic rst, start, start4;
  always #5 clk = ~clk;

  miter_result_checker_if #(.WIDTH(W)) bus ();
  miter_result_checker_if #(.WIDTH(W)) bus4 ();

  assign bus4.in_valid = bus.in_valid;
  assign bus4.in_gold  = bus.in_gold;
  assign bus4.in_gate  = bus.in_gate;
  assign bus4.in_mask  = bus.in_mask;
  assign bus4.in_last  = bus.in_last;

  logic           busy, done, pass;
  logic [CW-1:0]  cnt, fidx;
  logic [W-1:0]   fdiff;
  logic           busy4, done4, pass4;
  logic [CW4-1:0] cnt4, fidx4;
  logic [W-1:0]   fdiff4;

  miter_result_checker #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_if(bus.slave),
    .busy(busy), .done(done), .pass(pass),
    .mismatch_cnt(cnt), .first_idx(fidx), .first_diff(fdiff)
  );

  miter_result_checker #(.WIDTH(W), .CNT_W(CW4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .in_if(bus4.slave),
    .busy(busy4), .done(done4), .pass(pass4),
    .mismatch_cnt(cnt4), .first_idx(fidx4), .first_diff(fdiff4)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] q_gold[$];
  logic [W-1:0] q_gate[$];
  logic [W-1:0] q_mask[$];

  typedef struct {
    logic [W-1:0] gold;
    logic [W-1:0] gate;
    logic [W-1:0] mask;
    bit           exp_pass;
    logic [W-1:0] exp_diff;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_gold  = '0;
    bus.in_gate  = '0;
    bus.in_mask  = '0;
  endtask

  task automatic drive(input logic [W-1:0] g, input logic [W-1:0] t, input logic [W-1:0] m,
                       input bit last);
    bus.in_valid = 1'b1;
    bus.in_gold  = g;
    bus.in_gate  = t;
    bus.in_mask  = m;
    bus.in_last  = last;
  endtask

  task automatic clear_q();
    q_gold.delete();
    q_gate.delete();
    q_mask.delete();
  endtask

  task automatic push(input logic [W-1:0] g, input logic [W-1:0] t, input logic [W-1:0] m);
    q_gold.push_back(g);
    q_gate.push_back(t);
    q_mask.push_back(m);
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 6 && !done; k++) step();
    check(name, done, 1);
  endtask

  // Plays the queued beats as one run, optionally with an idle cycle after each beat.
  task automatic run_stream(input bit gaps, input bit with4);
    start  = 1'b1;
    start4 = with4;
    step();
    start  = 1'b0;
    start4 = 1'b0;
    check("start_ready", bus.in_ready, 1);
    for (int i = 0; i < q_gold.size(); i++) begin
      drive(q_gold[i], q_gate[i], q_mask[i], i == q_gold.size() - 1);
      step();
      if (done) break;
      if (gaps) begin
        idle_inputs();
        step();
        if (done) break;
      end
    end
    idle_inputs();
    wait_done("run_done");
  endtask

  // Run-level reference: judge the queued beats by the masked-difference rule.
  task automatic model(input int cw, output bit m_pass, output int m_cnt, output int m_idx,
                       output logic [W-1:0] m_diff);
    logic [W-1:0] d;
    int maxc;
    maxc   = (1 << cw) - 1;
    m_pass = 1'b1;
    m_cnt  = 0;
    m_idx  = 0;
    m_diff = '0;
    for (int i = 0; i < q_gold.size(); i++) begin
      d = (q_gold[i] ^ q_gate[i]) & ~q_mask[i];
      if (d != '0) begin
        if (m_pass) begin
          m_pass = 1'b0;
          m_idx  = i % (1 << cw);
          m_diff = d;
        end
        if (m_cnt < maxc) m_cnt++;
`ifdef MITER_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
  endtask

  task automatic check_model(input string tag);
    bit e_pass;
    int e_cnt, e_idx;
    logic [W-1:0] e_diff;
    model(CW, e_pass, e_cnt, e_idx, e_diff);
    check({tag, "_pass"}, pass, e_pass);
    check({tag, "_cnt"}, cnt, e_cnt);
    check({tag, "_idx"}, fidx, e_idx);
    check({tag, "_diff"}, fdiff, e_diff);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[7];
    bit   e_pass;
    int   e_cnt, e_idx;
    logic [W-1:0] e_diff, g, t, m;
    int   n;
    bit   gaps;

    tbl[0] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        1'b1, 32'h0};
    tbl[1] = '{32'h00000001, 32'h00000000, 32'h00000001, 1'b1, 32'h0};
    tbl[2] = '{32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 32'h00000001};
    tbl[3] = '{32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 1'b1, 32'h0};
    tbl[4] = '{32'hFFFF0000, 32'h0000FFFF, 32'h00FF00FF, 1'b0, 32'hFF00FF00};
    tbl[5] = '{32'h12345678, 32'h12345679, 32'h0,        1'b0, 32'h00000001};
    tbl[6] = '{32'h80000000, 32'h00000000, 32'h7FFFFFFF, 1'b0, 32'h80000000};

    rst    = 1'b1;
    start  = 1'b0;
    start4 = 1'b0;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    check("rst_ready", bus.in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_cnt", cnt, 0);
    check("rst_idx", fidx, 0);
    check("rst_diff", fdiff, 0);

    // Beats in IDLE are ignored, including one that coincides with start.
    for (int i = 0; i < 3; i++) begin
      drive(32'hFF, 32'h0, 32'h0, 1'b1);
      step();
      check("idle_ready", bus.in_ready, 0);
      check("idle_busy", busy, 0);
    end
    start = 1'b1;
    drive(32'hFF, 32'h0, 32'h0, 1'b0);
    step();
    start = 1'b0;
    drive(32'h5, 32'h5, 32'h0, 1'b0);
    step();
    drive(32'h6, 32'h6, 32'h0, 1'b1);
    step();
    idle_inputs();
    wait_done("idle_run_done");
    check("idle_run_pass", pass, 1);
    check("idle_run_cnt", cnt, 0);
    // Beats in DONE are ignored too.
    drive(32'hFF, 32'h0, 32'h0, 1'b1);
    step();
    step();
    idle_inputs();
    check("doneb_cnt", cnt, 0);
    check("doneb_pass", pass, 1);

    // Single-beat vector table.
    for (int i = 0; i < 7; i++) begin
      clear_q();
      push(tbl[i].gold, tbl[i].gate, tbl[i].mask);
      run_stream(1'b0, 1'b0);
      check("tbl_pass", pass, tbl[i].exp_pass);
      check("tbl_diff", fdiff, tbl[i].exp_diff);
      check("tbl_cnt", cnt, tbl[i].exp_pass ? 0 : 1);
    end

    // All-equal 8-beat run with exact drain timing.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("eq_ready", bus.in_ready, 1);
      drive(32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, i == 7);
      step();
    end
    idle_inputs();
    check("eq_drain_done", done, 0);
    check("eq_drain_busy", busy, 1);
    check("eq_drain_ready", bus.in_ready, 0);
    step();
    check("eq_done", done, 1);
    check("eq_busy", busy, 0);
    check("eq_pass", pass, 1);
    check("eq_cnt", cnt, 0);

    // Masked difference on beat 3.
    clear_q();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) push(32'h1, 32'h0, 32'h1);
      else push(32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0);
    end
    run_stream(1'b0, 1'b0);
    check("mask_pass", pass, 1);
    check_model("mask");

    // Failures on beats 2 and 5.
    clear_q();
    for (int i = 0; i < 8; i++) begin
      if (i == 2) push(32'h00F0, 32'h0, 32'h0);
      else if (i == 5) push(32'h0001, 32'h0, 32'h0);
      else push(32'h1234, 32'h1234, 32'h0);
    end
    run_stream(1'b0, 1'b0);
`ifdef MITER_STOP_ON_FAIL_EN
    check("multi_cnt", cnt, 1);
`else
    check("multi_cnt", cnt, 2);
`endif
    check("multi_idx", fidx, 2);
    check("multi_diff", fdiff, 32'h00F0);
    check("multi_pass", pass, 0);

    // Backpressure: valid every other cycle, only beat 3 fails.
    clear_q();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) push(32'h8, 32'h0, 32'h0);
      else push(32'h77, 32'h77, 32'h0);
    end
    run_stream(1'b1, 1'b0);
    check("bp_idx", fidx, 3);
    check("bp_cnt", cnt, 1);
    check("bp_busy", busy, 0);

    // start during RUN is ignored.
    start = 1'b1;
    step();
    start = 1'b0;
    drive(32'h1, 32'h1, 32'h0, 1'b0);
    step();
    start = 1'b1;
    drive(32'h2, 32'h2, 32'h0, 1'b0);
    step();
    start = 1'b0;
    drive(32'h40, 32'h0, 32'h0, 1'b0);
    step();
    if (!done) begin
      drive(32'h3, 32'h3, 32'h0, 1'b1);
      step();
    end
    idle_inputs();
    wait_done("srun_done");
    check("srun_idx", fidx, 2);
    check("srun_cnt", cnt, 1);
    check("srun_diff", fdiff, 32'h40);

    // Reset right after a failing beat is accepted.
    start = 1'b1;
    step();
    start = 1'b0;
    drive(32'hFF, 32'h0, 32'h0, 1'b0);
    step();
    rst = 1'b1;
    drive(32'hF0, 32'h0, 32'h0, 1'b0);
    step();
    rst = 1'b0;
    idle_inputs();
    check("mrst_ready", bus.in_ready, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_pass", pass, 0);
    check("mrst_cnt", cnt, 0);
    check("mrst_idx", fidx, 0);
    check("mrst_diff", fdiff, 0);
    step();
    step();
    check("mrst_cnt_later", cnt, 0);
    check("mrst_diff_later", fdiff, 0);
    clear_q();
    for (int i = 0; i < 4; i++) push(32'h5A5A, 32'h5A5A, 32'h0);
    run_stream(1'b0, 1'b0);
    check("mrst_run_pass", pass, 1);

    // Saturation and index wrap on the 4-bit counter instance.
    clear_q();
    for (int i = 0; i < 20; i++) push(32'h1 << (i % 32), 32'h0, 32'h0);
    run_stream(1'b0, 1'b1);
    check_model("sat16");
    model(CW4, e_pass, e_cnt, e_idx, e_diff);
    check("sat4_done", done4, 1);
    check("sat4_pass", pass4, e_pass);
    check("sat4_cnt", cnt4, e_cnt);
    check("sat4_idx", fidx4, e_idx);
    check("sat4_diff", fdiff4, e_diff);
`ifndef MITER_STOP_ON_FAIL_EN
    check("sat4_cnt_const", cnt4, 15);
`endif

    // Random runs against the reference model.
    for (int r = 0; r < 25; r++) begin
      clear_q();
      n    = $urandom_range(1, 12);
      gaps = $urandom_range(0, 1);
      for (int i = 0; i < n; i++) begin
        g = $urandom;
        t = g;
        if ($urandom_range(0, 2) == 0) t = g ^ (32'h1 << $urandom_range(0, 31));
        case ($urandom_range(0, 3))
          0:       m = 32'hFFFFFFFF;
          1:       m = $urandom;
          default: m = '0;
        endcase
        push(g, t, m);
      end
      run_stream(gaps, 1'b0);
      check_model("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
